// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage RISC-V pipeline.
// Combines load-use hazard detection, taken-branch flushing and data-memory
// wait handling (with timeout) into one set of pipeline register controls,
// and keeps saturating counts of stall cycles and branch flushes.
module pipeline_hazard_controller #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16,
   parameter int TO_W        = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_ex_mem_read,
   input  logic [4:0]       id_ex_rd,
   input  logic [4:0]       if_id_rs1,
   input  logic [4:0]       if_id_rs2,
   input  logic             if_id_use_rs1,
   input  logic             if_id_use_rs2,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_write,
   output logic             ex_mem_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERR      = 2'd2
   } state_e;

   // Last wait count that is still allowed before declaring a timeout.
   localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);
   localparam logic [TO_W-1:0] WAIT_ONE  = TO_W'(1);
   localparam logic [TO_W-1:0] WAIT_ZERO = {TO_W{1'b0}};

   state_e            state_r;
   state_e            state_nxt_s;
   logic [TO_W-1:0]   wait_cnt_r;
   logic [TO_W-1:0]   wait_cnt_nxt_s;
   logic [CNT_W-1:0]  stall_cnt_r;
   logic [CNT_W-1:0]  flush_cnt_r;

   logic              load_use_s;
   logic              freeze_s;
   logic              stall_inc_s;
   logic              flush_inc_s;
   logic              pc_write_s;
   logic              if_id_write_s;
   logic              id_ex_write_s;
   logic              ex_mem_write_s;
   logic              if_id_flush_s;
   logic              id_ex_bubble_s;
   logic              mem_err_s;

   // Saturating increment: holds at all-ones instead of wrapping to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                                input logic             en);
      logic [CNT_W-1:0] res;
      if (en && (val != {CNT_W{1'b1}})) begin
         res = val + CNT_W'(1);
      end else begin
         res = val;
      end
      return res;
   endfunction

   // A load in EX writing a register that ID reads; x0 never hazards.
   assign load_use_s = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                       ((if_id_use_rs1 && (id_ex_rd == if_id_rs1)) ||
                        (if_id_use_rs2 && (id_ex_rd == if_id_rs2)));

   // Memory is busy this cycle; a withdrawn request counts as ready.
   assign freeze_s = mem_req && !mem_ready;

   // State register and wait counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_RUN;
         wait_cnt_r <= WAIT_ZERO;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
      end
   end

   // Next-state and next wait-count selection.
   always_comb begin
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = wait_cnt_r;
      case (state_r)
         ST_RUN: begin
            if (freeze_s) begin
               state_nxt_s    = ST_MEM_WAIT;
               wait_cnt_nxt_s = WAIT_ONE;
            end else begin
               state_nxt_s    = ST_RUN;
               wait_cnt_nxt_s = WAIT_ZERO;
            end
         end
         ST_MEM_WAIT: begin
            if (!freeze_s) begin
               state_nxt_s    = ST_RUN;
               wait_cnt_nxt_s = WAIT_ZERO;
            end else if (wait_cnt_r == WAIT_LAST) begin
               state_nxt_s    = ST_ERR;
               wait_cnt_nxt_s = wait_cnt_r;
            end else begin
               state_nxt_s    = ST_MEM_WAIT;
               wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
            end
         end
         ST_ERR: begin
            // Only reset leaves the error state.
            state_nxt_s    = ST_ERR;
            wait_cnt_nxt_s = wait_cnt_r;
         end
         default: begin
            state_nxt_s    = ST_RUN;
            wait_cnt_nxt_s = WAIT_ZERO;
         end
      endcase
   end

   // Pipeline controls and counter-increment requests from state and inputs.
   always_comb begin
      pc_write_s     = 1'b1;
      if_id_write_s  = 1'b1;
      id_ex_write_s  = 1'b1;
      ex_mem_write_s = 1'b1;
      if_id_flush_s  = 1'b0;
      id_ex_bubble_s = 1'b0;
      mem_err_s      = 1'b0;
      stall_inc_s    = 1'b0;
      flush_inc_s    = 1'b0;
      if (!reset) begin
         // Held in reset: free-running defaults regardless of inputs.
         pc_write_s = 1'b1;
      end else begin
         case (state_r)
            // MEM_WAIT with memory released behaves exactly like RUN, and
            // a frozen MEM_WAIT cycle looks just like a freeze seen in RUN.
            ST_RUN, ST_MEM_WAIT: begin
               if (freeze_s) begin
                  pc_write_s     = 1'b0;
                  if_id_write_s  = 1'b0;
                  id_ex_write_s  = 1'b0;
                  ex_mem_write_s = 1'b0;
                  stall_inc_s    = 1'b1;
               end else if (ex_branch_taken) begin
                  // The instruction in ID is killed, so a load-use on it is moot.
                  if_id_flush_s  = 1'b1;
                  id_ex_bubble_s = 1'b1;
                  flush_inc_s    = 1'b1;
               end else if (load_use_s) begin
                  pc_write_s     = 1'b0;
                  if_id_write_s  = 1'b0;
                  id_ex_bubble_s = 1'b1;
                  stall_inc_s    = 1'b1;
               end else begin
                  pc_write_s = 1'b1;
               end
            end
            ST_ERR: begin
               pc_write_s     = 1'b0;
               if_id_write_s  = 1'b0;
               id_ex_write_s  = 1'b0;
               ex_mem_write_s = 1'b0;
               mem_err_s      = 1'b1;
            end
            default: begin
               pc_write_s = 1'b1;
            end
         endcase
      end
   end

   // Saturating stall and flush event counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
      end else begin
         stall_cnt_r <= sat_inc(stall_cnt_r, stall_inc_s);
         flush_cnt_r <= sat_inc(flush_cnt_r, flush_inc_s);
      end
   end

   assign pc_write     = pc_write_s;
   assign if_id_write  = if_id_write_s;
   assign id_ex_write  = id_ex_write_s;
   assign ex_mem_write = ex_mem_write_s;
   assign if_id_flush  = if_id_flush_s;
   assign id_ex_bubble = id_ex_bubble_s;
   assign mem_err      = mem_err_s;
   assign stall_cnt    = stall_cnt_r;
   assign flush_cnt    = flush_cnt_r;

endmodule
